// File: rtl/branch_resolve_queue.sv
// Branch resolve queue: in-order tracking of predicted branches from decode to execute,
// producing registered predictor feedback and mispredict redirects. Optional statistics via BRANCH_STATS_EN.
module branch_resolve_queue #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_dec_valid,
    input  logic [ADDR_W-1:0] i_dec_pc,
    input  logic              i_dec_prediction,
    input  logic [ADDR_W-1:0] i_dec_recovery,
    output logic              o_dec_ready,
    input  logic              i_ex_valid,
    input  logic              i_ex_outcome,
    input  logic              i_flush,
    output logic              o_fb_valid,
    output logic [ADDR_W-1:0] o_fb_pc,
    output logic              o_fb_prediction,
    output logic              o_fb_outcome,
    output logic              o_redirect_valid,
    output logic [ADDR_W-1:0] o_redirect_pc,
    output logic              o_err,
    output logic [CNT_W-1:0]  o_branch_count,
    output logic [CNT_W-1:0]  o_miss_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    typedef enum logic {RUN, RECOVER} state_e;

    state_e            state_q, state_d;
    logic              alive_q;
    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              fbValid_q, fbValid_d;
    logic [ADDR_W-1:0] fbPc_q, fbPc_d;
    logic              fbPred_q, fbPred_d;
    logic              fbOutcome_q, fbOutcome_d;
    logic              redirectValid_q, redirectValid_d;
    logic [ADDR_W-1:0] redirectPc_q, redirectPc_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] memPc   [DEPTH];
    logic              memPred [DEPTH];
    logic [ADDR_W-1:0] memRec  [DEPTH];

    logic             decReady;
    logic             pushAcc;
    logic             pushWrite;
    logic             resolve;
    logic             mispredict;
    logic             flushEff;
    logic [PTR_W-1:0] rdPtrPop;

    // alive_q keeps decode stalled until the first clock edge after reset release.
    always_comb begin
        decReady   = alive_q && (state_q == RUN) && (count_q < FULL_CNT);
        pushAcc    = i_dec_valid && decReady;
        resolve    = i_ex_valid && (count_q != '0);
        mispredict = resolve && (i_ex_outcome != memPred[rdPtr_q]);
        flushEff   = i_flush && (state_q == RUN);
        rdPtrPop   = resolve ? rdPtr_q + PTR_W'(1) : rdPtr_q;

        state_d   = state_q;
        rdPtr_d   = rdPtrPop;
        wrPtr_d   = wrPtr_q;
        count_d   = count_q;
        pushWrite = 1'b0;

        case (state_q)
            RUN:     state_d = mispredict ? RECOVER : RUN;
            RECOVER: state_d = RUN;
            default: state_d = RUN;
        endcase

        if (mispredict) begin
            wrPtr_d = rdPtrPop;
            count_d = '0;
        end else if (flushEff) begin
            wrPtr_d = rdPtrPop;
            count_d = '0;
        end else begin
            pushWrite = pushAcc;
            if (pushAcc) begin
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
            case ({pushAcc, resolve})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end

        fbValid_d       = resolve;
        fbPc_d          = resolve ? memPc[rdPtr_q] : fbPc_q;
        fbPred_d        = resolve ? memPred[rdPtr_q] : fbPred_q;
        fbOutcome_d     = resolve ? i_ex_outcome : fbOutcome_q;
        redirectValid_d = mispredict;
        redirectPc_d    = mispredict ? memRec[rdPtr_q] : redirectPc_q;

        // Stalled pushes during RECOVER are legal and deliberately excluded here.
        err_d = err_q
              || (i_ex_valid && (count_q == '0))
              || (i_dec_valid && !decReady && (state_q == RUN));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= RUN;
            alive_q         <= 1'b0;
            rdPtr_q         <= '0;
            wrPtr_q         <= '0;
            count_q         <= '0;
            fbValid_q       <= 1'b0;
            fbPc_q          <= '0;
            fbPred_q        <= 1'b0;
            fbOutcome_q     <= 1'b0;
            redirectValid_q <= 1'b0;
            redirectPc_q    <= '0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            alive_q         <= 1'b1;
            rdPtr_q         <= rdPtr_d;
            wrPtr_q         <= wrPtr_d;
            count_q         <= count_d;
            fbValid_q       <= fbValid_d;
            fbPc_q          <= fbPc_d;
            fbPred_q        <= fbPred_d;
            fbOutcome_q     <= fbOutcome_d;
            redirectValid_q <= redirectValid_d;
            redirectPc_q    <= redirectPc_d;
            err_q           <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (pushWrite) begin
            memPc[wrPtr_q]   <= i_dec_pc;
            memPred[wrPtr_q] <= i_dec_prediction;
            memRec[wrPtr_q]  <= i_dec_recovery;
        end
    end

    assign o_dec_ready      = decReady;
    assign o_fb_valid       = fbValid_q;
    assign o_fb_pc          = fbPc_q;
    assign o_fb_prediction  = fbPred_q;
    assign o_fb_outcome     = fbOutcome_q;
    assign o_redirect_valid = redirectValid_q;
    assign o_redirect_pc    = redirectPc_q;
    assign o_err            = err_q;

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] branchCount_q, missCount_q;

    // Pushes discarded by a same-cycle squash or flush never enter the queue and are not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branchCount_q <= '0;
            missCount_q   <= '0;
        end else begin
            if (pushWrite && (branchCount_q != '1)) begin
                branchCount_q <= branchCount_q + CNT_W'(1);
            end
            if (mispredict && (missCount_q != '1)) begin
                missCount_q <= missCount_q + CNT_W'(1);
            end
        end
    end

    assign o_branch_count = branchCount_q;
    assign o_miss_count   = missCount_q;
`else
    assign o_branch_count = '0;
    assign o_miss_count   = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed self-checking bench for branch_resolve_queue (DEPTH=4, ADDR_W=32).
module tb_branch_resolve_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        decValid;
    logic [31:0] decPc;
    logic        decPred;
    logic [31:0] decRec;
    logic        decReady;
    logic        exValid;
    logic        exOutcome;
    logic        flush;
    logic        fbValid;
    logic [31:0] fbPc;
    logic        fbPred;
    logic        fbOutcome;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        err;
    logic [31:0] branchCount;
    logic [31:0] missCount;

    int checks   = 0;
    int failures = 0;

    branch_resolve_queue #(.ADDR_W(32), .DEPTH(4), .CNT_W(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_dec_valid      (decValid),
        .i_dec_pc         (decPc),
        .i_dec_prediction (decPred),
        .i_dec_recovery   (decRec),
        .o_dec_ready      (decReady),
        .i_ex_valid       (exValid),
        .i_ex_outcome     (exOutcome),
        .i_flush          (flush),
        .o_fb_valid       (fbValid),
        .o_fb_pc          (fbPc),
        .o_fb_prediction  (fbPred),
        .o_fb_outcome     (fbOutcome),
        .o_redirect_valid (redirectValid),
        .o_redirect_pc    (redirectPc),
        .o_err            (err),
        .o_branch_count   (branchCount),
        .o_miss_count     (missCount)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs and returns 1 time unit after the capturing edge.
    task automatic applyStimulus(input logic dv, input logic [31:0] pc, input logic pred, input logic [31:0] rec,
                                 input logic ev, input logic outc, input logic fl);
        decValid  = dv;
        decPc     = pc;
        decPred   = pred;
        decRec    = rec;
        exValid   = ev;
        exOutcome = outc;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pushOne(input logic [31:0] pc, input logic pred, input logic [31:0] rec);
        applyStimulus(1'b1, pc, pred, rec, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic resolveOne(input logic outc);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, outc, 1'b0);
    endtask

    task automatic pulseReset();
        decValid = 1'b0; exValid = 1'b0; flush = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        decValid = 1'b0; decPc = '0; decPred = 1'b0; decRec = '0;
        exValid = 1'b0; exOutcome = 1'b0; flush = 1'b0;
        #12;
        checkOutput("rst_fb_valid", fbValid, 0);
        checkOutput("rst_dec_ready", decReady, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_redirect_pc", redirectPc, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("ready_after_rst", decReady, 1);

        // Correct prediction
        pushOne(32'h100, 1'b1, 32'h108);
        checkOutput("t1_ready", decReady, 1);
        checkOutput("t1_no_fb_yet", fbValid, 0);
        resolveOne(1'b1);
        checkOutput("t1_fb_valid", fbValid, 1);
        checkOutput("t1_fb_pc", fbPc, 32'h100);
        checkOutput("t1_fb_pred", fbPred, 1);
        checkOutput("t1_fb_outcome", fbOutcome, 1);
        checkOutput("t1_redirect", redirectValid, 0);
        idle();
        checkOutput("t1_fb_pulse", fbValid, 0);
        checkOutput("t1_fb_pc_hold", fbPc, 32'h100);

        // Mispredict squashes younger entries and a same-cycle push
        pushOne(32'h100, 1'b0, 32'h200);
        pushOne(32'h110, 1'b1, 32'h118);
        pushOne(32'h120, 1'b1, 32'h128);
        applyStimulus(1'b1, 32'h130, 1'b1, 32'h138, 1'b1, 1'b1, 1'b0);
        checkOutput("t2_fb_valid", fbValid, 1);
        checkOutput("t2_fb_pc", fbPc, 32'h100);
        checkOutput("t2_fb_pred", fbPred, 0);
        checkOutput("t2_redirect_valid", redirectValid, 1);
        checkOutput("t2_redirect_pc", redirectPc, 32'h200);
        checkOutput("t2_recover_ready", decReady, 0);
        applyStimulus(1'b1, 32'h130, 1'b1, 32'h138, 1'b0, 1'b0, 1'b0);
        checkOutput("t2_stall_no_err", err, 0);
        checkOutput("t2_redirect_pulse", redirectValid, 0);
        checkOutput("t2_ready_back", decReady, 1);
        resolveOne(1'b1);
        checkOutput("t2_empty_err", err, 1);
        checkOutput("t2_empty_no_fb", fbValid, 0);

        // Full queue, refused push with pop, pointer wrap
        pulseReset();
        checkOutput("t3_err_cleared", err, 0);
        pushOne(32'h10, 1'b1, 32'h14);
        pushOne(32'h20, 1'b1, 32'h24);
        pushOne(32'h30, 1'b1, 32'h34);
        pushOne(32'h40, 1'b1, 32'h44);
        checkOutput("t3_full_ready", decReady, 0);
        checkOutput("t3_full_no_err", err, 0);
        applyStimulus(1'b1, 32'h50, 1'b1, 32'h54, 1'b1, 1'b1, 1'b0);
        checkOutput("t3_pop0_pc", fbPc, 32'h10);
        checkOutput("t3_refused_err", err, 1);
        checkOutput("t3_ready_after_pop", decReady, 1);
        applyStimulus(1'b1, 32'h50, 1'b1, 32'h54, 1'b1, 1'b1, 1'b0);
        checkOutput("t3_pop1_pc", fbPc, 32'h20);
        checkOutput("t3_pop1_valid", fbValid, 1);
        resolveOne(1'b1);
        checkOutput("t3_pop2_pc", fbPc, 32'h30);
        checkOutput("t3_b2b_valid", fbValid, 1);
        resolveOne(1'b1);
        checkOutput("t3_pop3_pc", fbPc, 32'h40);
        resolveOne(1'b1);
        checkOutput("t3_pop4_pc_wrap", fbPc, 32'h50);
        checkOutput("t3_pop4_redirect", redirectValid, 0);

        // Flush with simultaneous resolve
        pulseReset();
        pushOne(32'hA00, 1'b1, 32'hA08);
        pushOne(32'hA10, 1'b0, 32'hA18);
        pushOne(32'hA20, 1'b1, 32'hA28);
        applyStimulus(1'b1, 32'hA30, 1'b1, 32'hA38, 1'b1, 1'b1, 1'b1);
        checkOutput("t4_fb_valid", fbValid, 1);
        checkOutput("t4_fb_pc", fbPc, 32'hA00);
        checkOutput("t4_no_redirect", redirectValid, 0);
        checkOutput("t4_ready", decReady, 1);
        resolveOne(1'b0);
        checkOutput("t4_empty_err", err, 1);
        checkOutput("t4_empty_no_fb", fbValid, 0);
        checkOutput("t4_fb_pc_hold", fbPc, 32'hA00);

        // Asynchronous reset between edges
        pushOne(32'hB00, 1'b1, 32'hB08);
        pushOne(32'hB10, 1'b1, 32'hB18);
        resolveOne(1'b1);
        checkOutput("t5_fb_valid", fbValid, 1);
        checkOutput("t5_fb_pc", fbPc, 32'hB00);
        decValid = 1'b0; exValid = 1'b0; flush = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t5_async_fb_valid", fbValid, 0);
        checkOutput("t5_async_fb_pc", fbPc, 0);
        checkOutput("t5_async_err", err, 0);
        checkOutput("t5_async_ready", decReady, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t5_no_stale_fb", fbValid, 0);
        checkOutput("t5_ready", decReady, 1);
        resolveOne(1'b1);
        checkOutput("t5_queue_empty_err", err, 1);
        checkOutput("t5_queue_empty_fb", fbValid, 0);

        // Statistics: 6 offered pushes, one discarded by a mispredict, 2 mispredicts
        pulseReset();
        pushOne(32'hC00, 1'b0, 32'hC80);
        pushOne(32'hC10, 1'b1, 32'hC90);
        applyStimulus(1'b1, 32'hC20, 1'b1, 32'hCA0, 1'b1, 1'b1, 1'b0);
        checkOutput("t6_redirect1_pc", redirectPc, 32'hC80);
        idle();
        pushOne(32'hC30, 1'b1, 32'hCB0);
        pushOne(32'hC40, 1'b0, 32'hCC0);
        pushOne(32'hC50, 1'b1, 32'hCD0);
        resolveOne(1'b1);
        checkOutput("t6_correct_pc", fbPc, 32'hC30);
        checkOutput("t6_correct_redirect", redirectValid, 0);
        resolveOne(1'b1);
        checkOutput("t6_redirect2_valid", redirectValid, 1);
        checkOutput("t6_redirect2_pc", redirectPc, 32'hCC0);
        idle();
`ifdef BRANCH_STATS_EN
        checkOutput("t6_branch_count", branchCount, 5);
        checkOutput("t6_miss_count", missCount, 2);
`else
        checkOutput("t6_branch_count", branchCount, 0);
        checkOutput("t6_miss_count", missCount, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
